// File: rtl/xadc_pkg.sv
// rtl/xadc_pkg.sv - shared XADC temperature path types, thresholds and class codes
package xadc_pkg;

  // Reader FSM encoding; 3 bits so stray codes fall into the default arm
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_PUBLISH = 3'd3
  } state_t;

  // Station class codes, shared with the material system
  typedef enum logic [1:0] {
    CLASS_AMBIENT = 2'd0,
    CLASS_HOT     = 2'd1,
    CLASS_COLD    = 2'd2
  } class_t;

  // Temperature code thresholds, shared with the material system
  localparam logic [11:0] THRESH_COLD = 12'd1200;
  localparam logic [11:0] THRESH_HOT  = 12'd1900;

  // VAUX6 result register
  localparam logic [6:0] DEFAULT_CHANNEL_ADDR = 7'h16;

endpackage

// File: rtl/temp_classifier.sv
// rtl/temp_classifier.sv - combinational station class of a 12-bit averaged temperature
module temp_classifier
  import xadc_pkg::*;
(
  input  logic [11:0] avg,
  output class_t      temp_class
);

  // Hot wins over cold; the thresholds never overlap so order is only for clarity
  always_comb begin
    temp_class = CLASS_AMBIENT;
    if (avg > THRESH_HOT) begin
      temp_class = CLASS_HOT;
    end else if (avg < THRESH_COLD) begin
      temp_class = CLASS_COLD;
    end
  end

endmodule

// File: rtl/xadc_temp_reader.sv
// rtl/xadc_temp_reader.sv - XADC DRP temperature reader and averager; optional TEMP_CLASS_EN
module xadc_temp_reader
  import xadc_pkg::*;
#(
  parameter logic [6:0] CHANNEL_ADDR   = DEFAULT_CHANNEL_ADDR,
  parameter int         AVG_LOG2       = 3,
  parameter int         TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        resetN,
  input  logic        eoc,
  input  logic        drdy,
  input  logic [15:0] doIn,
  output logic        den,
  output logic        dwe,
  output logic [6:0]  daddr,
  output logic [11:0] digitalTemp,
  output logic        ready,
  output logic        timeoutErr
`ifdef TEMP_CLASS_EN
  ,
  output logic [1:0]  tempClass
`endif
);

  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] SAMPLES = CNT_W'(1 << AVG_LOG2);
  localparam logic [7:0] TIMEOUT_LOAD = 8'(TIMEOUT_CYCLES);

  state_t             state, state_next;
  logic               den_next;
  logic [ACC_W-1:0]   acc, acc_next;
  logic [CNT_W-1:0]   cnt, cnt_next, cnt_inc;
  logic [7:0]         timer, timer_next;
  logic [11:0]        temp_next;
  logic               ready_next;
  logic               terr_next;
  logic [11:0]        avg;
  logic               unused_dolow;

  // The DRP write port is never used; the address is fixed to one channel
  assign dwe   = 1'b0;
  assign daddr = CHANNEL_ADDR;

  // Low nibble of the DRP word carries no temperature information
  assign unused_dolow = &{1'b0, doIn[3:0]};

  assign cnt_inc = cnt + CNT_W'(1);
  assign avg     = 12'(acc >> AVG_LOG2);

`ifdef TEMP_CLASS_EN
  class_t     avg_class;
  logic [1:0] class_next;

  temp_classifier u_classifier (
    .avg        (avg),
    .temp_class (avg_class)
  );
`endif

  // Next-state and next-register values; every register holds by default
  always_comb begin
    state_next = state;
    den_next   = 1'b0;
    acc_next   = acc;
    cnt_next   = cnt;
    timer_next = timer;
    temp_next  = digitalTemp;
    ready_next = ready;
    terr_next  = timeoutErr;
`ifdef TEMP_CLASS_EN
    class_next = tempClass;
`endif
    case (state)
      S_IDLE: begin
        if (eoc) begin
          state_next = S_REQ;
          den_next   = 1'b1;
        end
      end
      S_REQ: begin
        timer_next = TIMEOUT_LOAD;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (drdy) begin
          acc_next   = acc + ACC_W'(doIn[15:4]);
          cnt_next   = cnt_inc;
          state_next = (cnt_inc == SAMPLES) ? S_PUBLISH : S_IDLE;
        end else if (timer == 8'd0) begin
          // Partial accumulation survives a lost read
          terr_next  = 1'b1;
          state_next = S_IDLE;
        end else begin
          timer_next = timer - 8'd1;
        end
      end
      S_PUBLISH: begin
        temp_next  = avg;
        ready_next = 1'b1;
        acc_next   = '0;
        cnt_next   = '0;
`ifdef TEMP_CLASS_EN
        class_next = avg_class;
`endif
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any read in progress
  always_ff @(posedge CLK) begin
    if (!resetN) begin
      state       <= S_IDLE;
      den         <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      timer       <= 8'd0;
      digitalTemp <= 12'd0;
      ready       <= 1'b0;
      timeoutErr  <= 1'b0;
`ifdef TEMP_CLASS_EN
      tempClass   <= CLASS_AMBIENT;
`endif
    end else begin
      state       <= state_next;
      den         <= den_next;
      acc         <= acc_next;
      cnt         <= cnt_next;
      timer       <= timer_next;
      digitalTemp <= temp_next;
      ready       <= ready_next;
      timeoutErr  <= terr_next;
`ifdef TEMP_CLASS_EN
      tempClass   <= class_next;
`endif
    end
  end

endmodule

// File: tb/tb_xadc_temp_reader.sv
// tb/tb_xadc_temp_reader.sv - self-checking bench for xadc_temp_reader (optional TEMP_CLASS_EN)
module tb_xadc_temp_reader;

  localparam int L_A = 3;
  localparam int L_B = 0;
  localparam int N_A = 1 << L_A;
  localparam int N_B = 1 << L_B;
  localparam int TMO = 10;

  logic        CLK;
  logic        resetN;
  logic        eoc;
  logic        drdy;
  logic [15:0] doIn;

  logic        den_a, dwe_a, ready_a, terr_a;
  logic [6:0]  daddr_a;
  logic [11:0] temp_a;
  logic        den_b, dwe_b, ready_b, terr_b;
  logic [6:0]  daddr_b;
  logic [11:0] temp_b;
`ifdef TEMP_CLASS_EN
  logic [1:0]  cls_a, cls_b;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int den_seen = 0;
  int den_expected = 0;

  // Reference model: queues of accepted samples, averaged once full
  int          q0[$];
  int          q1[$];
  logic [11:0] exp_t0, exp_t1;
  logic        exp_r0, exp_r1, exp_terr;
  logic [1:0]  exp_c0, exp_c1;

  xadc_temp_reader #(.CHANNEL_ADDR(7'h16), .AVG_LOG2(L_A), .TIMEOUT_CYCLES(TMO)) dut_a (
    .CLK(CLK), .resetN(resetN), .eoc(eoc), .drdy(drdy), .doIn(doIn),
    .den(den_a), .dwe(dwe_a), .daddr(daddr_a), .digitalTemp(temp_a),
    .ready(ready_a), .timeoutErr(terr_a)
`ifdef TEMP_CLASS_EN
    , .tempClass(cls_a)
`endif
  );

  xadc_temp_reader #(.CHANNEL_ADDR(7'h16), .AVG_LOG2(L_B), .TIMEOUT_CYCLES(TMO)) dut_b (
    .CLK(CLK), .resetN(resetN), .eoc(eoc), .drdy(drdy), .doIn(doIn),
    .den(den_b), .dwe(dwe_b), .daddr(daddr_b), .digitalTemp(temp_b),
    .ready(ready_b), .timeoutErr(terr_b)
`ifdef TEMP_CLASS_EN
    , .tempClass(cls_b)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) if (den_a) den_seen++;

  function automatic logic [1:0] class_of(input int avg);
    if (avg > 1900) return 2'd1;
    if (avg < 1200) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_clear();
    q0.delete(); q1.delete();
    exp_t0 = 12'd0; exp_t1 = 12'd0;
    exp_r0 = 1'b0;  exp_r1 = 1'b0;
    exp_c0 = 2'd0;  exp_c1 = 2'd0;
    exp_terr = 1'b0;
  endtask

  task automatic model_push(input int code);
    int s;
    q0.push_back(code);
    q1.push_back(code);
    if (q0.size() == N_A) begin
      s = 0;
      foreach (q0[i]) s += q0[i];
      exp_t0 = 12'(s / N_A); exp_r0 = 1'b1; exp_c0 = class_of(s / N_A);
      q0.delete();
    end
    if (q1.size() == N_B) begin
      s = 0;
      foreach (q1[i]) s += q1[i];
      exp_t1 = 12'(s / N_B); exp_r1 = 1'b1; exp_c1 = class_of(s / N_B);
      q1.delete();
    end
  endtask

  // One eoc-driven DRP read; entered and left at #1 after a rising edge
  task automatic do_read(input logic [11:0] code, input int lat, input bit respond, input bit dbl);
    logic [11:0] old_t0, old_t1;
    eoc = 1'b1;
    den_expected++;
    @(posedge CLK); #1;
    if (!dbl) eoc = 1'b0;
    n_cmp++;
    if (den_a !== 1'b1 || den_b !== 1'b1) begin
      n_err++; $display("FAIL den_rise got a=%0b b=%0b want 1", den_a, den_b);
    end
    @(posedge CLK); #1;
    eoc = 1'b0;
    n_cmp++;
    if (den_a !== 1'b0 || den_b !== 1'b0) begin
      n_err++; $display("FAIL den_fall got a=%0b b=%0b want 0", den_a, den_b);
    end
    if (!respond) begin
      repeat (TMO) @(posedge CLK);
      #1;
      n_cmp++;
      if (terr_a !== exp_terr || terr_b !== exp_terr) begin
        n_err++; $display("FAIL timeout_early got a=%0b b=%0b want %0b", terr_a, terr_b, exp_terr);
      end
      @(posedge CLK); #1;
      exp_terr = 1'b1;
      n_cmp++;
      if (terr_a !== 1'b1 || terr_b !== 1'b1) begin
        n_err++; $display("FAIL timeout_rise got a=%0b b=%0b want 1", terr_a, terr_b);
      end
      return;
    end
    for (int k = 0; k < lat; k++) begin
      @(posedge CLK); #1;
      n_cmp++;
      if (den_a !== 1'b0) begin
        n_err++; $display("FAIL den_wait got %0b want 0", den_a);
      end
    end
    drdy = 1'b1;
    doIn = {code, 4'($urandom)};
    @(posedge CLK); #1;
    drdy = 1'b0;
    doIn = 16'($urandom);
    old_t0 = exp_t0; old_t1 = exp_t1;
    model_push(int'(code));
    n_cmp++;
    if (temp_a !== old_t0 || temp_b !== old_t1) begin
      n_err++; $display("FAIL temp_hold got a=%0d b=%0d want a=%0d b=%0d", temp_a, temp_b, old_t0, old_t1);
    end
    @(posedge CLK); #1;
    n_cmp++;
    if (temp_a !== exp_t0 || ready_a !== exp_r0 || terr_a !== exp_terr) begin
      n_err++; $display("FAIL read_a got temp=%0d ready=%0b terr=%0b want temp=%0d ready=%0b terr=%0b",
                        temp_a, ready_a, terr_a, exp_t0, exp_r0, exp_terr);
    end
    n_cmp++;
    if (temp_b !== exp_t1 || ready_b !== exp_r1 || terr_b !== exp_terr) begin
      n_err++; $display("FAIL read_b got temp=%0d ready=%0b terr=%0b want temp=%0d ready=%0b terr=%0b",
                        temp_b, ready_b, terr_b, exp_t1, exp_r1, exp_terr);
    end
`ifdef TEMP_CLASS_EN
    n_cmp++;
    if (cls_a !== exp_c0 || cls_b !== exp_c1) begin
      n_err++; $display("FAIL class got a=%0d b=%0d want a=%0d b=%0d", cls_a, cls_b, exp_c0, exp_c1);
    end
`endif
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    model_clear();
    n_cmp++;
    if ({den_a, dwe_a, daddr_a, temp_a, ready_a, terr_a} !== {1'b0, 1'b0, 7'h16, 12'd0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_a got den=%0b dwe=%0b daddr=%h temp=%0d ready=%0b terr=%0b want 0 0 16 0 0 0",
                        den_a, dwe_a, daddr_a, temp_a, ready_a, terr_a);
    end
    n_cmp++;
    if ({den_b, dwe_b, daddr_b, temp_b, ready_b, terr_b} !== {1'b0, 1'b0, 7'h16, 12'd0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_b got den=%0b dwe=%0b daddr=%h temp=%0d ready=%0b terr=%0b want 0 0 16 0 0 0",
                        den_b, dwe_b, daddr_b, temp_b, ready_b, terr_b);
    end
`ifdef TEMP_CLASS_EN
    n_cmp++;
    if (cls_a !== 2'd0 || cls_b !== 2'd0) begin
      n_err++; $display("FAIL reset_class got a=%0d b=%0d want 0", cls_a, cls_b);
    end
`endif
    resetN = 1'b1;
  endtask

  task automatic test_constant_2000();
    for (int i = 0; i < N_A; i++) begin
      n_cmp++;
      if (ready_a !== 1'b0) begin
        n_err++; $display("FAIL ready_early got %0b want 0 at sample %0d", ready_a, i);
      end
      do_read(12'd2000, i % 3, 1'b1, 1'b0);
    end
    n_cmp++;
    if (temp_a !== 12'd2000 || ready_a !== 1'b1) begin
      n_err++; $display("FAIL avg_2000 got temp=%0d ready=%0b want 2000 1", temp_a, ready_a);
    end
  endtask

  task automatic test_truncation();
    for (int i = 0; i < N_A; i++) do_read(12'(1000 + i), 2, 1'b1, 1'b0);
    n_cmp++;
    if (temp_a !== 12'd1003) begin
      n_err++; $display("FAIL avg_trunc got %0d want 1003", temp_a);
    end
`ifdef TEMP_CLASS_EN
    n_cmp++;
    if (cls_a !== 2'd2) begin
      n_err++; $display("FAIL class_cold got %0d want 2", cls_a);
    end
`endif
  endtask

  task automatic test_timeout();
    do_read(12'd0, 0, 1'b0, 1'b0);
    do_read(12'd1800, 4, 1'b1, 1'b0);
    n_cmp++;
    if (terr_a !== 1'b1) begin
      n_err++; $display("FAIL timeout_sticky got %0b want 1", terr_a);
    end
  endtask

  task automatic test_back_to_back();
    do_read(12'd2500, 1, 1'b1, 1'b1);
  endtask

  task automatic test_avg_one();
    do_read(12'd4095, 0, 1'b1, 1'b0);
    n_cmp++;
    if (temp_b !== 12'd4095 || ready_b !== 1'b1) begin
      n_err++; $display("FAIL avg1_max got temp=%0d ready=%0b want 4095 1", temp_b, ready_b);
    end
    do_read(12'd0, 0, 1'b1, 1'b0);
    n_cmp++;
    if (temp_b !== 12'd0 || ready_b !== 1'b1) begin
      n_err++; $display("FAIL avg1_zero got temp=%0d ready=%0b want 0 1", temp_b, ready_b);
    end
  endtask

  task automatic test_reset_mid_wait();
    resetN = 1'b0;
    @(posedge CLK); #1;
    resetN = 1'b1;
    model_clear();
    for (int i = 0; i < 5; i++) do_read(12'(1100 + 7 * i), 1, 1'b1, 1'b0);
    eoc = 1'b1;
    den_expected++;
    @(posedge CLK); #1;
    eoc = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    resetN = 1'b0;
    @(posedge CLK); #1;
    model_clear();
    n_cmp++;
    if ({den_a, temp_a, ready_a, terr_a, den_b, temp_b, ready_b, terr_b} !== 30'd0) begin
      n_err++; $display("FAIL reset_wait got a=%0b/%0d/%0b/%0b b=%0b/%0d/%0b/%0b want all 0",
                        den_a, temp_a, ready_a, terr_a, den_b, temp_b, ready_b, terr_b);
    end
    resetN = 1'b1;
    for (int i = 0; i < N_A; i++) do_read(12'd1500, 3, 1'b1, 1'b0);
    n_cmp++;
    if (temp_a !== 12'd1500 || ready_a !== 1'b1) begin
      n_err++; $display("FAIL avg_1500 got temp=%0d ready=%0b want 1500 1", temp_a, ready_a);
    end
`ifdef TEMP_CLASS_EN
    n_cmp++;
    if (cls_a !== 2'd0) begin
      n_err++; $display("FAIL class_ambient got %0d want 0", cls_a);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        // Stray drdy while idle must be ignored
        drdy = 1'b1;
        doIn = 16'($urandom);
        @(posedge CLK); #1;
        drdy = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) begin
        do_read(12'd0, 0, 1'b0, 1'b0);
      end else begin
        do_read(12'($urandom), $urandom_range(0, 8), 1'b1, $urandom_range(0, 3) == 0);
      end
    end
  endtask

  initial begin
    resetN = 1'b0;
    eoc    = 1'b0;
    drdy   = 1'b0;
    doIn   = 16'd0;
    model_clear();
    test_reset();
    test_constant_2000();
    test_truncation();
    test_timeout();
    test_back_to_back();
    test_avg_one();
    test_reset_mid_wait();
    test_random();
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++;
    if (den_seen !== den_expected) begin
      n_err++; $display("FAIL den_count got %0d want %0d", den_seen, den_expected);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
